// File: rtl/tinytpu_serial_mm.sv
// Bit-serial signed N x N matrix multiplier: loads X and Y over LANES-wide ports,
// runs one MAC per cycle into Z (optionally accumulating), then streams Z out under valid/ready.
module tinytpu_serial_mm #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int LANES = 1,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             acc_mode,
    input  logic             load_en,
    input  logic [LANES-1:0] data_in_x,
    input  logic [LANES-1:0] data_in_y,
    output logic             rx_ready,
    output logic [LANES-1:0] data_out_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int NN      = N * N;
    localparam int IN_GPE  = D_W / LANES;
    localparam int OUT_GPE = ACC_W / LANES;
    localparam int EW      = (NN > 1) ? $clog2(NN) : 1;
    localparam int IGW     = (IN_GPE > 1) ? $clog2(IN_GPE) : 1;
    localparam int OGW     = (OUT_GPE > 1) ? $clog2(OUT_GPE) : 1;
    localparam int NW      = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, TX} state_t;

    state_t state_q, state_d;

    logic [D_W-1:0]   x_mem [NN];
    logic [D_W-1:0]   y_mem [NN];
    logic [ACC_W-1:0] z_mem [NN];

    logic [EW-1:0]  ld_elem;
    logic [IGW-1:0] ld_grp;
    logic [NW-1:0]  i_cnt, j_cnt, k_cnt;
    logic [EW-1:0]  tx_elem;
    logic [OGW-1:0] tx_grp;
    logic           done_q;

    logic load_fire, load_last, mac_fire, mac_last, tx_fire, tx_last;

    int x_idx, y_idx, z_idx;
    logic signed [D_W-1:0]     x_op, y_op;
    logic signed [2*D_W-1:0]   prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic        [ACC_W-1:0]   z_cur, mac_sum, z_tx, tx_word;

    // init overrides every other qualifier, so each fire term is masked by it
    assign load_fire = (state_q == LOAD) && load_en && !init;
    assign load_last = (ld_elem == EW'(NN - 1)) && (ld_grp == IGW'(IN_GPE - 1));
    assign mac_fire  = (state_q == COMPUTE) && !init;
    assign mac_last  = (i_cnt == NW'(N - 1)) && (j_cnt == NW'(N - 1)) && (k_cnt == NW'(N - 1));
    assign tx_fire   = (state_q == TX) && out_ready && !init;
    assign tx_last   = (tx_elem == EW'(NN - 1)) && (tx_grp == OGW'(OUT_GPE - 1));

    assign rx_ready  = (state_q == LOAD);
    assign out_valid = (state_q == TX);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD:    if (load_fire && load_last) state_d = COMPUTE;
                COMPUTE: if (mac_last)               state_d = TX;
                TX:      if (tx_fire && tx_last)     state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Operand and output-word selection as explicit mux loops over the element arrays
    always_comb begin
        x_idx = int'(i_cnt) * N + int'(k_cnt);
        y_idx = int'(k_cnt) * N + int'(j_cnt);
        z_idx = int'(i_cnt) * N + int'(j_cnt);
        x_op  = '0;
        y_op  = '0;
        z_cur = '0;
        z_tx  = '0;
        for (int e = 0; e < NN; e++) begin
            if (e == x_idx) x_op = x_mem[e];
            if (e == y_idx) y_op = y_mem[e];
            if (e == z_idx) z_cur = z_mem[e];
            if (e == int'(tx_elem)) z_tx = z_mem[e];
        end
    end

    assign prod       = x_op * y_op;
    assign prod_ext   = ACC_W'(prod);
    assign mac_sum    = z_cur + prod_ext;
    assign tx_word    = z_tx << (int'(tx_grp) * LANES);
    assign data_out_z = out_valid ? tx_word[ACC_W-1 -: LANES] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NN; e++) begin
                x_mem[e] <= '0;
                y_mem[e] <= '0;
                z_mem[e] <= '0;
            end
            ld_elem <= '0;
            ld_grp  <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            k_cnt   <= '0;
            tx_elem <= '0;
            tx_grp  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (init) begin
                ld_elem <= '0;
                ld_grp  <= '0;
                i_cnt   <= '0;
                j_cnt   <= '0;
                k_cnt   <= '0;
                tx_elem <= '0;
                tx_grp  <= '0;
                if (!acc_mode) begin
                    for (int e = 0; e < NN; e++) z_mem[e] <= '0;
                end
            end else begin
                // Each element is assembled MSB-first by shifting groups in at the bottom
                if (load_fire) begin
                    for (int e = 0; e < NN; e++) begin
                        if (e == int'(ld_elem)) begin
                            x_mem[e] <= (x_mem[e] << LANES) | D_W'(data_in_x);
                            y_mem[e] <= (y_mem[e] << LANES) | D_W'(data_in_y);
                        end
                    end
                    if (ld_grp == IGW'(IN_GPE - 1)) begin
                        ld_grp  <= '0;
                        ld_elem <= load_last ? '0 : ld_elem + 1'b1;
                    end else begin
                        ld_grp <= ld_grp + 1'b1;
                    end
                end
                if (mac_fire) begin
                    for (int e = 0; e < NN; e++) begin
                        if (e == z_idx) z_mem[e] <= mac_sum;
                    end
                    if (k_cnt == NW'(N - 1)) begin
                        k_cnt <= '0;
                        if (j_cnt == NW'(N - 1)) begin
                            j_cnt <= '0;
                            i_cnt <= (i_cnt == NW'(N - 1)) ? '0 : i_cnt + 1'b1;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                if (tx_fire) begin
                    if (tx_grp == OGW'(OUT_GPE - 1)) begin
                        tx_grp  <= '0;
                        tx_elem <= tx_last ? '0 : tx_elem + 1'b1;
                    end else begin
                        tx_grp <= tx_grp + 1'b1;
                    end
                    if (tx_last) done_q <= 1'b1;
                end
            end
        end
    end

endmodule
